mdu_issue: RTL and testbench

E-stage issue and interlock controller for the multiply/divide unit (`mdu`) in the pipelined MIPS core.
- Holds the E-stage copy of the MD operation class and gates it with the exception flush before presenting `Op` to `mdu`.
- Generates the D-stage stall that keeps MD instructions out of E while a mult/div is in flight.
- Shadows the `mdu` latency counter to flag protocol mismatches.
- Keeps saturating performance counters.

---
 rtl/md_pkg.sv | 30 +++
 rtl/md_shadow_ctr.sv | 65 ++++++
 rtl/mdu_issue.sv | 73 +++++++
 tb/tb_mdu_issue.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Purpose: shared MD-class encodings, default latencies and helpers for the MD issue path.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package md_pkg;

    // MD operation class carried from D to E and presented to the mdu as Op
    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    // Busy cycles the mdu spends after accepting a long op
    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

    // Long ops occupy the mdu for several cycles; everything else is single-shot
    function automatic logic md_is_long(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_shadow_ctr.sv
// Purpose: shadow of the mdu latency counter; flags any disagreement with mdu Busy.
// Latency: counter loads on the issue edge; proto_err rises one edge after a mismatch.
// Backpressure: none; observes only, never stalls.
module md_shadow_ctr
    import md_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] mdu_op,
    input  logic       mdu_busy,
    output logic       proto_err
);

    localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int SH_W    = ($clog2(MAX_LAT + 1) > 4) ? $clog2(MAX_LAT + 1) : 4;

    localparam logic [SH_W-1:0] SH_MUL = SH_W'(MUL_LAT);
    localparam logic [SH_W-1:0] SH_DIV = SH_W'(DIV_LAT);
    localparam logic [SH_W-1:0] SH_ONE = SH_W'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]      state;
    logic [SH_W-1:0] sh;
    logic            long_issue;
    logic            sh_busy;

    assign long_issue = md_is_long(mdu_op);
    assign sh_busy    = (sh != '0);

    // IDLE/WAIT tracking of the expected mdu busy window plus sticky mismatch flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            sh        <= '0;
            proto_err <= 1'b0;
        end else begin
            if (mdu_busy != sh_busy) begin
                proto_err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (long_issue) begin
                        sh    <= md_is_div(mdu_op) ? SH_DIV : SH_MUL;
                        state <= ST_WAIT;
                    end
                end
                default: begin
                    // A long op seen here is illegal and deliberately not reloaded
                    if (sh <= SH_ONE) begin
                        sh    <= '0;
                        state <= ST_IDLE;
                    end else begin
                        sh <= sh - SH_ONE;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/mdu_issue.sv
// Purpose: E-stage MD issue register, flush gating, D-stage interlock and perf counters.
// Latency: mdu_op/stall are combinational; e_md_op and counters update on the next edge.
// Backpressure: stall holds any MD instruction in D while the mdu is issuing or busy.
module mdu_issue
    import md_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       d_md_op,
    input  logic             e_flush,
    input  logic             mdu_busy,
    output logic [3:0]       mdu_op,
    output logic [3:0]       e_md_op,
    output logic             stall,
    output logic             proto_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] md_issued
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic long_issue;
    logic busy_eff;

    // A flushed E op never reaches the mdu, so it neither issues nor stalls
    assign mdu_op     = e_flush ? MD_NONE : e_md_op;
    assign long_issue = md_is_long(mdu_op);
    assign busy_eff   = long_issue | mdu_busy;
    // Every MD class waits, since all of them touch HI/LO
    assign stall      = (d_md_op != MD_NONE) & busy_eff;

    // E-stage MD class: bubble on stall or flush, otherwise advance from D
    always_ff @(posedge clk) begin
        if (reset) begin
            e_md_op <= MD_NONE;
        end else if (stall || e_flush) begin
            e_md_op <= MD_NONE;
        end else begin
            e_md_op <= d_md_op;
        end
    end

    // Saturating counts of stalled cycles and issued long ops
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            md_issued    <= '0;
        end else begin
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_ONE;
            end
            if (long_issue && (md_issued != '1)) begin
                md_issued <= md_issued + CNT_ONE;
            end
        end
    end

    md_shadow_ctr #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_shadow (
        .clk       (clk),
        .reset     (reset),
        .mdu_op    (mdu_op),
        .mdu_busy  (mdu_busy),
        .proto_err (proto_err)
    );

endmodule

// File: tb/tb_mdu_issue.sv
// Purpose: bench for mdu_issue with a behavioural mdu and a cycle-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mdu_issue;
    import md_pkg::*;

    localparam int MUL_L = 5;
    localparam int DIV_L = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  d_md_op;
    logic        e_flush;
    logic        mdu_busy;

    logic [3:0]  mdu_op, e_md_op;
    logic        stall, proto_err;
    logic [31:0] stall_cycles, md_issued;

    logic [3:0]  mdu_op4, e_md_op4;
    logic        stall4, proto_err4;
    logic [3:0]  stall_cycles4, md_issued4;

    int n_cmp = 0;
    int n_bad = 0;

    // reference state
    int m_e, m_stalls, m_issued;
    bit m_perr;

    // behavioural mdu: busy for LAT cycles after accepting a long op
    int   mdu_left;
    logic force_busy;

    always #5 clk = ~clk;

    mdu_issue #(.MUL_LAT(MUL_L), .DIV_LAT(DIV_L), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .d_md_op(d_md_op), .e_flush(e_flush), .mdu_busy(mdu_busy),
        .mdu_op(mdu_op), .e_md_op(e_md_op), .stall(stall), .proto_err(proto_err),
        .stall_cycles(stall_cycles), .md_issued(md_issued)
    );

    mdu_issue #(.MUL_LAT(MUL_L), .DIV_LAT(DIV_L), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .d_md_op(d_md_op), .e_flush(e_flush), .mdu_busy(mdu_busy),
        .mdu_op(mdu_op4), .e_md_op(e_md_op4), .stall(stall4), .proto_err(proto_err4),
        .stall_cycles(stall_cycles4), .md_issued(md_issued4)
    );

    always @(posedge clk) begin
        if (reset) mdu_left <= 0;
        else if (mdu_left > 0) mdu_left <= mdu_left - 1;
        else if (mdu_op >= 4'd1 && mdu_op <= 4'd4) mdu_left <= (mdu_op >= 4'd3) ? DIV_L : MUL_L;
    end

    assign mdu_busy = (mdu_left != 0) || force_busy;

    function automatic int sat4(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    // one clock cycle: drive, check against the model at negedge, advance the model
    task automatic cycle(input logic [3:0] d, input logic fl, output logic obs_stall, output logic [3:0] obs_op);
        int exp_op;
        bit lng, exp_stall, mism;
        d_md_op = d;
        e_flush = fl;
        @(negedge clk);
        exp_op    = fl ? 0 : m_e;
        lng       = (exp_op >= 1) && (exp_op <= 4);
        exp_stall = (d != 0) && (lng || mdu_busy);
        mism      = (mdu_busy != (mdu_left != 0));
        n_cmp++; if (e_md_op !== 4'(m_e)) begin n_bad++; $display("FAIL e_md_op: got %0d want %0d", e_md_op, m_e); end
        n_cmp++; if (mdu_op !== 4'(exp_op)) begin n_bad++; $display("FAIL mdu_op: got %0d want %0d", mdu_op, exp_op); end
        n_cmp++; if (stall !== exp_stall) begin n_bad++; $display("FAIL stall: got %0d want %0d", stall, exp_stall); end
        n_cmp++; if (proto_err !== m_perr) begin n_bad++; $display("FAIL proto_err: got %0d want %0d", proto_err, m_perr); end
        n_cmp++; if (stall_cycles !== 32'(m_stalls)) begin n_bad++; $display("FAIL stall_cycles: got %0d want %0d", stall_cycles, m_stalls); end
        n_cmp++; if (md_issued !== 32'(m_issued)) begin n_bad++; $display("FAIL md_issued: got %0d want %0d", md_issued, m_issued); end
        n_cmp++; if (stall_cycles4 !== 4'(sat4(m_stalls))) begin n_bad++; $display("FAIL stall_cycles_w4: got %0d want %0d", stall_cycles4, sat4(m_stalls)); end
        n_cmp++; if (md_issued4 !== 4'(sat4(m_issued))) begin n_bad++; $display("FAIL md_issued_w4: got %0d want %0d", md_issued4, sat4(m_issued)); end
        obs_stall = stall;
        obs_op    = mdu_op;
        @(posedge clk);
        if (mism) m_perr = 1'b1;
        m_e = (exp_stall || fl) ? 0 : int'(d);
        if (lng) m_issued++;
        if (exp_stall) m_stalls++;
        #1;
    endtask

    task automatic do_reset(input logic [3:0] d);
        reset      = 1'b1;
        d_md_op    = d;
        e_flush    = 1'b0;
        force_busy = 1'b0;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        m_e      = 0;
        m_stalls = 0;
        m_issued = 0;
        m_perr   = 1'b0;
    endtask

    // hold d in D until it gets past the interlock; returns stalled cycle count
    task automatic run_until_free(input logic [3:0] d, output int nstall);
        logic s;
        logic [3:0] o;
        nstall = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(d, 1'b0, s, o);
            if (!s) return;
            nstall++;
        end
        n_cmp++; n_bad++;
        $display("FAIL stall_timeout: got %0d stalled cycles want release", nstall);
    endtask

    task automatic test_reset();
        do_reset(MD_NONE);
        @(negedge clk);
        n_cmp++;
        if ({e_md_op, mdu_op, stall, proto_err} !== 10'd0 || stall_cycles !== 32'd0 || md_issued !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_state: got e=%0d op=%0d st=%0d pe=%0d sc=%0d mi=%0d want all 0",
                     e_md_op, mdu_op, stall, proto_err, stall_cycles, md_issued);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mult_stall();
        logic s; logic [3:0] o; int n;
        do_reset(MD_NONE);
        cycle(MD_MULT, 1'b0, s, o);
        run_until_free(MD_MFHI, n);
        n_cmp++; if (n !== 6) begin n_bad++; $display("FAIL mult_stall_len: got %0d want 6", n); end
        n_cmp++; if (e_md_op !== MD_MFHI) begin n_bad++; $display("FAIL mult_mfhi_in_e: got %0d want 5", e_md_op); end
        n_cmp++; if (md_issued !== 32'd1) begin n_bad++; $display("FAIL mult_issued: got %0d want 1", md_issued); end
        n_cmp++; if (stall_cycles !== 32'd6) begin n_bad++; $display("FAIL mult_stall_cnt: got %0d want 6", stall_cycles); end
        cycle(MD_NONE, 1'b0, s, o);
    endtask

    task automatic test_div_stall();
        logic s; logic [3:0] o; int n;
        do_reset(MD_NONE);
        cycle(MD_DIV, 1'b0, s, o);
        run_until_free(MD_MFLO, n);
        n_cmp++; if (n !== 11) begin n_bad++; $display("FAIL div_stall_len: got %0d want 11", n); end
        cycle(MD_NONE, 1'b0, s, o);
        n_cmp++; if (proto_err !== 1'b0) begin n_bad++; $display("FAIL div_proto: got %0d want 0", proto_err); end
    endtask

    task automatic test_flush_issue();
        logic s; logic [3:0] o;
        do_reset(MD_NONE);
        cycle(MD_MULT, 1'b0, s, o);
        cycle(MD_MFHI, 1'b1, s, o);
        n_cmp++; if (o !== MD_NONE) begin n_bad++; $display("FAIL flush_op: got %0d want 0", o); end
        n_cmp++; if (s !== 1'b0) begin n_bad++; $display("FAIL flush_stall: got %0d want 0", s); end
        for (int i = 0; i < 3; i++) cycle(MD_NONE, 1'b0, s, o);
        n_cmp++; if (md_issued !== 32'd0) begin n_bad++; $display("FAIL flush_issued: got %0d want 0", md_issued); end
        n_cmp++; if (proto_err !== 1'b0) begin n_bad++; $display("FAIL flush_idle: got %0d want 0", proto_err); end
    endtask

    task automatic test_back_to_back();
        logic s0, s1, s2, s3; logic [3:0] o0, o1, o2, o3;
        do_reset(MD_NONE);
        cycle(MD_MTHI, 1'b0, s0, o0);
        cycle(MD_MTLO, 1'b0, s1, o1);
        cycle(MD_MFLO, 1'b0, s2, o2);
        cycle(MD_NONE, 1'b0, s3, o3);
        n_cmp++; if ({s0, s1, s2, s3} !== 4'b0) begin n_bad++; $display("FAIL b2b_stall: got %b want 0000", {s0, s1, s2, s3}); end
        n_cmp++; if ({o1, o2, o3} !== {MD_MTHI, MD_MTLO, MD_MFLO}) begin
            n_bad++; $display("FAIL b2b_ops: got %0d,%0d,%0d want 7,8,6", o1, o2, o3);
        end
    endtask

    task automatic test_proto();
        logic s; logic [3:0] o;
        do_reset(MD_NONE);
        force_busy = 1'b1;
        cycle(MD_NONE, 1'b0, s, o);
        force_busy = 1'b0;
        n_cmp++; if (proto_err !== 1'b1) begin n_bad++; $display("FAIL proto_set: got %0d want 1", proto_err); end
        for (int i = 0; i < 4; i++) cycle(MD_NONE, 1'b0, s, o);
        n_cmp++; if (proto_err !== 1'b1) begin n_bad++; $display("FAIL proto_sticky: got %0d want 1", proto_err); end
        do_reset(MD_NONE);
        n_cmp++; if (proto_err !== 1'b0) begin n_bad++; $display("FAIL proto_clear: got %0d want 0", proto_err); end
    endtask

    task automatic test_saturate_and_reset();
        logic s; logic [3:0] o; int n;
        do_reset(MD_NONE);
        for (int k = 0; k < 2; k++) begin
            cycle(MD_DIV, 1'b0, s, o);
            run_until_free(MD_MFHI, n);
        end
        n_cmp++; if (stall_cycles4 !== 4'd15) begin n_bad++; $display("FAIL sat_w4: got %0d want 15", stall_cycles4); end
        n_cmp++; if (stall_cycles !== 32'd22) begin n_bad++; $display("FAIL sat_w32: got %0d want 22", stall_cycles); end
        cycle(MD_DIVU, 1'b0, s, o);
        for (int i = 0; i < 3; i++) cycle(MD_MFHI, 1'b0, s, o);
        do_reset(MD_MFHI);
        @(negedge clk);
        n_cmp++;
        if ({e_md_op, mdu_op, stall, proto_err} !== 10'd0 || stall_cycles !== 32'd0 || md_issued !== 32'd0
            || stall_cycles4 !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_mid_wait: got e=%0d op=%0d st=%0d pe=%0d sc=%0d mi=%0d want all 0",
                     e_md_op, mdu_op, stall, proto_err, stall_cycles, md_issued);
        end
        @(posedge clk);
        m_e = int'(MD_MFHI);
        #1;
        cycle(MD_NONE, 1'b0, s, o);
    endtask

    task automatic test_random();
        logic s; logic [3:0] o; logic [3:0] d; logic fl;
        do_reset(MD_NONE);
        for (int i = 0; i < 400; i++) begin
            d  = ($urandom_range(0, 9) < 4) ? MD_NONE : 4'($urandom_range(1, 8));
            fl = ($urandom_range(0, 15) == 0);
            cycle(d, fl, s, o);
        end
    endtask

    initial begin
        reset      = 1'b1;
        d_md_op    = MD_NONE;
        e_flush    = 1'b0;
        force_busy = 1'b0;
        test_reset();
        test_mult_stall();
        test_div_stall();
        test_flush_issue();
        test_back_to_back();
        test_proto();
        test_saturate_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
